lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  pipeline request present.
REQ-005 req_ready  out  1  block can accept a request; high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  in  10  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  valid with resp_valid; request was misaligned or illegal.
REQ-014 mem_read  out  1  data-memory read strobe.
REQ-015 mem_write  out  1  data-memory write strobe.
REQ-016 mem_addr  out  8  word address, equal to req_addr[9:2] of the accepted request.
REQ-017 mem_wdata  out  32  data-memory write data.
REQ-018 mem_rdata  in  32  data-memory read data, valid in the cycle after a mem_read cycle.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, DATA, WRITE, RESP; a request is accepted on a posedge with req_valid=1 in IDLE, and the request fields are registered.
REQ-020 Acceptance transitions SHALL be:
- error -> RESP
- load -> READ
- word store -> WRITE
- byte/half store -> READ
REQ-021 Post-acceptance transitions SHALL be:
- READ -> DATA
- DATA -> RESP (load) or WRITE (store)
- WRITE -> RESP
- RESP -> IDLE
REQ-022 Error SHALL be: size 11; half with addr[0]=1; or word with addr[1:0]!=00. An error request SHALL cause no memory access.
REQ-023 mem_read SHALL be 1 only in READ, and mem_write SHALL be 1 only in WRITE; the two SHALL never be high together.
REQ-024 mem_wdata SHALL be 0 outside WRITE.
REQ-025 Byte lane SHALL be addr[1:0], selecting bits [8*lane+7 : 8*lane]. Half lane SHALL be addr[1], selecting bits [16*addr[1]+15 : 16*addr[1]].
REQ-026 In DATA for a load, the selected lane of mem_rdata SHALL be extended per req_unsigned and registered into resp_rdata.
REQ-027 In DATA for a byte/half store, the selected lane of mem_rdata SHALL be replaced by req_wdata[7:0] or [15:0], and the merged word registered for WRITE.
REQ-028 For a word store, WRITE SHALL drive mem_wdata = req_wdata.
REQ-029 resp_valid SHALL be 1 only in RESP.
REQ-030 Latency from the accepting edge E to resp_valid high SHALL be:
- error: after E+0
- word store: after E+1
- load: after E+2
- byte/half store: after E+3
REQ-031 req_valid SHALL be ignored while not in IDLE; no request is queued.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and clear all registers. While reset is asserted:
- resp_valid, resp_err, mem_read and mem_write SHALL be 0
- resp_rdata, mem_addr and mem_wdata SHALL be 0
- req_ready SHALL be 1
- req_valid SHALL be ignored
REQ-033 Reset mid-operation SHALL abandon the operation; no mem_write and no resp_valid SHALL follow.

Verification
REQ-034 Word store 0xDEADBEEF to 0x010 -> one mem_write with mem_addr 0x04, mem_wdata 0xDEADBEEF, no mem_read; resp_valid after E+1, resp_err 0.
REQ-035 Memory word 0x80FF7F01, load byte at 0x013:
- signed -> resp_rdata 0xFFFFFF80
- unsigned -> 0x00000080
- resp_valid after E+2 in both cases
REQ-036 Memory word 0x11223344, store half 0xABCD at 0x012 -> mem_read then mem_write of 0xABCD3344 to mem_addr 0x04; resp after E+3.
REQ-037 Word load at 0x011 -> resp_err 1, resp_rdata 0, no mem_read or mem_write; resp_valid after E+0.
REQ-038 rst_n pulsed low during READ of a byte store -> no mem_write, all outputs 0; req_ready 1 after release, and a next load completes normally.
REQ-039 req_valid held high with a second request during a load -> the second request is accepted only on the edge after RESP, and exactly one memory access is made per request.

Source files
------------

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit. It accepts one request at a time and drives a
//            single-port word memory. Byte and half stores are handled as a
//            read-modify-write. Loads are sign- or zero-extended.
// Revision : 1.0 - initial release
// ============================================================================
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready = (r_state == IDLE);

  // Misalignment / illegal-size check on the incoming request
  always_comb begin
    w_err = 1'b0;
    case (req_size)
      2'b01:   w_err = req_addr[0];
      2'b10:   w_err = (req_addr[1:0] != 2'b00);
      2'b11:   w_err = 1'b1;
      default: w_err = 1'b0;
    endcase
  end

  // Lane extraction, load extension and store merge from the read word
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase

    w_merged = mem_rdata;
    if (r_size == 2'b00) begin
      case (r_lane)
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        2'd3:    w_merged[31:24] = r_wdata[7:0];
        default: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  // Control FSM with registered memory strobes and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= 16'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 8'h0;
      mem_wdata  <= 32'h0;
    end else begin
      // Strobes are single-state pulses; each state re-asserts what it needs
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_wdata  <= 32'h0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            mem_addr   <= req_addr[9:2];
            resp_rdata <= 32'h0;
            if (w_err) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && (req_size == 2'b10)) begin
              r_state   <= WRITE;
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              // Loads and partial stores both start with a read
              r_state  <= READ;
              mem_read <= 1'b1;
            end
          end
        end
        READ: r_state <= DATA;
        DATA: begin
          if (r_we) begin
            r_state   <= WRITE;
            mem_write <= 1'b1;
            mem_wdata <= w_merged;
          end else begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= w_load;
          end
        end
        WRITE: begin
          r_state    <= RESP;
          resp_valid <= 1'b1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed self-checking bench for lsu with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = 10'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:255];
  int          n_reads = 0;
  int          n_writes = 0;
  int          n_resps = 0;
  int          both_seen = 0;
  logic [7:0]  last_waddr = 8'h0;
  logic [31:0] last_wdata = 32'h0;

  lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= mem[mem_addr];
      n_reads   <= n_reads + 1;
    end
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      last_waddr    <= mem_addr;
      last_wdata    <= mem_wdata;
      n_writes      <= n_writes + 1;
    end
    if (mem_read && mem_write) both_seen <= both_seen + 1;
    if (resp_valid) n_resps <= n_resps + 1;
  end

  // Issue one request and wait (bounded) for its response
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [9:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    total++; if (mem_addr !== 8'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    req_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; logic er; int r0, w0;
    mem[4] = 32'h0;
    r0 = n_reads; w0 = n_writes;
    do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, lat, rd, er);
    total++; if (lat != 1) begin bad++; $display("FAIL wst_latency got=%0d exp=1", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL wst_err got=%b exp=0", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wst_rdata got=%h exp=0", rd); end
    total++; if (n_reads - r0 != 0) begin bad++; $display("FAIL wst_reads got=%0d exp=0", n_reads - r0); end
    total++; if (n_writes - w0 != 1) begin bad++; $display("FAIL wst_writes got=%0d exp=1", n_writes - w0); end
    total++; if (last_waddr !== 8'h04) begin bad++; $display("FAIL wst_addr got=%h exp=04", last_waddr); end
    total++; if (last_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wst_wdata got=%h exp=deadbeef", last_wdata); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL wst_resp_pulse got=%b exp=0", resp_valid); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL wst_wdata_idle got=%h exp=0", mem_wdata); end
  endtask

  task automatic test_loads();
    int lat; logic [31:0] rd; logic er; int r0, w0;
    logic [9:0]  addrs [5] = '{10'h013, 10'h013, 10'h012, 10'h011, 10'h010};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000007F, 32'h80FF7F01};
    mem[4] = 32'h80FF7F01;
    for (int i = 0; i < 5; i++) begin
      r0 = n_reads; w0 = n_writes;
      do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rd, er);
      total++; if (rd !== exps[i]) begin bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rd, exps[i]); end
      total++; if (lat != 2) begin bad++; $display("FAIL load%0d_latency got=%0d exp=2", i, lat); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL load%0d_err got=%b exp=0", i, er); end
      total++; if ((n_reads - r0 != 1) || (n_writes - w0 != 0)) begin bad++;
        $display("FAIL load%0d_access got=r%0d/w%0d exp=r1/w0", i, n_reads - r0, n_writes - w0); end
    end
  endtask

  task automatic test_partial_store();
    int lat; logic [31:0] rd; logic er; int r0, w0;
    mem[4] = 32'h11223344;
    r0 = n_reads; w0 = n_writes;
    do_req(1'b1, 2'b01, 1'b0, 10'h012, 32'h0000ABCD, lat, rd, er);
    total++; if (lat != 3) begin bad++; $display("FAIL hst_latency got=%0d exp=3", lat); end
    total++; if ((n_reads - r0 != 1) || (n_writes - w0 != 1)) begin bad++;
      $display("FAIL hst_access got=r%0d/w%0d exp=r1/w1", n_reads - r0, n_writes - w0); end
    total++; if (last_wdata !== 32'hABCD3344) begin bad++; $display("FAIL hst_wdata got=%h exp=abcd3344", last_wdata); end
    total++; if (last_waddr !== 8'h04) begin bad++; $display("FAIL hst_addr got=%h exp=04", last_waddr); end
    mem[5] = 32'h11223344;
    do_req(1'b1, 2'b00, 1'b0, 10'h015, 32'hFFFFFF55, lat, rd, er);
    total++; if (mem[5] !== 32'h11225544) begin bad++; $display("FAIL bst_mem got=%h exp=11225544", mem[5]); end
    total++; if (lat != 3) begin bad++; $display("FAIL bst_latency got=%0d exp=3", lat); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL bst_rdata got=%h exp=0", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; int r0, w0;
    logic [9:0] addrs [3] = '{10'h011, 10'h020, 10'h013};
    logic [1:0] sizes [3] = '{2'b10, 2'b11, 2'b01};
    logic       wes   [3] = '{1'b0, 1'b1, 1'b1};
    mem[4] = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      r0 = n_reads; w0 = n_writes;
      do_req(wes[i], sizes[i], 1'b0, addrs[i], 32'h12345678, lat, rd, er);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL err%0d_flag got=%b exp=1", i, er); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL err%0d_rdata got=%h exp=0", i, rd); end
      total++; if (lat != 0) begin bad++; $display("FAIL err%0d_latency got=%0d exp=0", i, lat); end
      total++; if ((n_reads - r0 != 0) || (n_writes - w0 != 0)) begin bad++;
        $display("FAIL err%0d_access got=r%0d/w%0d exp=r0/w0", i, n_reads - r0, n_writes - w0); end
    end
    total++; if (mem[4] !== 32'hCAFEF00D) begin bad++; $display("FAIL err_mem got=%h exp=cafef00d", mem[4]); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; int w0, v0;
    mem[6] = 32'hA5A5A5A5;
    w0 = n_writes; v0 = n_resps;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_addr = 10'h018; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rmid_in_read got=%b exp=1", mem_read); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0) begin bad++;
      $display("FAIL rmid_strobes got=%b exp=0000", {resp_valid, resp_err, mem_read, mem_write}); end
    total++; if ({resp_rdata, mem_addr, mem_wdata} !== 72'h0) begin bad++;
      $display("FAIL rmid_data got=%h/%h/%h exp=0", resp_rdata, mem_addr, mem_wdata); end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (n_writes - w0 != 0) begin bad++; $display("FAIL rmid_writes got=%0d exp=0", n_writes - w0); end
    total++; if (n_resps - v0 != 0) begin bad++; $display("FAIL rmid_resps got=%0d exp=0", n_resps - v0); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", req_ready); end
    total++; if (mem[6] !== 32'hA5A5A5A5) begin bad++; $display("FAIL rmid_mem got=%h exp=a5a5a5a5", mem[6]); end
    do_req(1'b0, 2'b01, 1'b1, 10'h01A, 32'h0, lat, rd, er);
    total++; if (rd !== 32'h0000A5A5 || lat != 2) begin bad++;
      $display("FAIL rmid_next_load got=%h lat=%0d exp=0000a5a5 lat=2", rd, lat); end
  endtask

  task automatic test_back_to_back();
    int r0, w0;
    int resp_at [2];
    int nresp;
    logic [31:0] rd0;
    logic        ready_e3, ready_e4;
    mem[4] = 32'h80FF7F01;
    mem[8] = 32'h0;
    r0 = n_reads; w0 = n_writes;
    resp_at = '{-1, -1};
    nresp = 0; rd0 = 32'h0; ready_e3 = 1'b0; ready_e4 = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b1; req_addr = 10'h013; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'b10; req_addr = 10'h020; req_wdata = 32'h12345678;
    for (int c = 0; c < 9; c++) begin
      if (c == 3) ready_e3 = req_ready;
      if (c == 4) ready_e4 = req_ready;
      if (resp_valid && nresp < 2) begin
        resp_at[nresp] = c;
        if (nresp == 0) rd0 = resp_rdata;
        nresp++;
        if (nresp == 2) req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (resp_at[0] != 2) begin bad++; $display("FAIL b2b_first_resp got=%0d exp=2", resp_at[0]); end
    total++; if (rd0 !== 32'h00000080) begin bad++; $display("FAIL b2b_first_rdata got=%h exp=00000080", rd0); end
    total++; if (ready_e3 !== 1'b1 || ready_e4 !== 1'b0) begin bad++;
      $display("FAIL b2b_accept_edge got=%b%b exp=10", ready_e3, ready_e4); end
    total++; if (resp_at[1] != 5) begin bad++; $display("FAIL b2b_second_resp got=%0d exp=5", resp_at[1]); end
    total++; if ((n_reads - r0 != 1) || (n_writes - w0 != 1)) begin bad++;
      $display("FAIL b2b_access got=r%0d/w%0d exp=r1/w1", n_reads - r0, n_writes - w0); end
    total++; if (mem[8] !== 32'h12345678) begin bad++; $display("FAIL b2b_mem got=%h exp=12345678", mem[8]); end
    total++; if (both_seen != 0) begin bad++; $display("FAIL rw_overlap got=%0d exp=0", both_seen); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_word_store();
    test_loads();
    test_partial_store();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
